// File: rtl/data_mem_port_if.sv
// Load/store request and response bundle between the core's memory stage
// and the data memory port. The master drives requests; the slave answers.
interface data_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_port.sv
// Data memory port: takes one byte-addressed load/store at a time, drives a
// 1-cycle-latency word RAM, does read-modify-write for byte/half stores and
// returns sign/zero-extended load data or an error response.
module data_mem_port #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_port_if.slave        bus,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  state_t state_q, state_d;

  // Request fields captured at acceptance
  logic                  we_q,    we_d;
  logic [ADDR_WIDTH-1:0] word_q,  word_d;
  logic [1:0]            lane_q,  lane_d;
  logic [1:0]            size_q,  size_d;
  logic                  uns_q,   uns_d;
  logic [31:0]           wdata_q, wdata_d;

  // Registered RAM-side and response outputs
  logic                  ram_ren_q,   ram_ren_d;
  logic                  ram_wen_q,   ram_wen_d;
  logic [ADDR_WIDTH-1:0] ram_raddr_q, ram_raddr_d;
  logic [ADDR_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  logic                  req_ready;
  logic                  accept;
  logic                  addr_hi_bad;
  logic                  req_bad;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [31:0]           load_ext;
  logic [31:0]           merged_word;
  logic [3:0]            byte_hit;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = bus.req_valid && req_ready;
  assign req_word  = bus.req_addr[ADDR_WIDTH+1:2];

  // Any address bit above the RAM's byte range makes the request illegal
  assign addr_hi_bad = (bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0;

  // Request legality: size encoding, natural alignment and address range
  always_comb begin
    req_bad = addr_hi_bad;
    case (bus.req_size)
      SIZE_BYTE: req_bad = addr_hi_bad;
      SIZE_HALF: req_bad = addr_hi_bad || bus.req_addr[0];
      SIZE_WORD: req_bad = addr_hi_bad || (bus.req_addr[1:0] != 2'd0);
      default:   req_bad = 1'b1;
    endcase
  end

  // Load path: pick the addressed lane out of the RAM word and extend it
  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte = ram_rdata[8*lane_q +: 8];
    sel_half = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_ext = ram_rdata;
    case (size_q)
      SIZE_BYTE: load_ext = uns_q ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_ext = uns_q ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default:   load_ext = ram_rdata;
    endcase
  end

  // Store path: each byte lane either takes new store data or keeps the
  // old RAM contents; half stores cover two adjacent lanes
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam int         HB   = gi % 2;
      logic [7:0] new_byte;

      assign byte_hit[gi] = ((size_q == SIZE_BYTE) && (lane_q == LANE)) ||
                            ((size_q == SIZE_HALF) && (lane_q[1] == LANE[1]));
      assign new_byte     = (size_q == SIZE_BYTE) ? wdata_q[7:0] : wdata_q[8*HB +: 8];
      assign merged_word[8*gi +: 8] = byte_hit[gi] ? new_byte : ram_rdata[8*gi +: 8];
    end
  endgenerate

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    word_d      = word_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    ram_ren_d   = 1'b0;
    ram_wen_d   = 1'b0;
    ram_raddr_d = ram_raddr_q;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          word_d  = req_word;
          lane_d  = bus.req_addr[1:0];
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          if (req_bad) begin
            // Rejected without touching the RAM
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (bus.req_we && (bus.req_size == SIZE_WORD)) begin
            // Full-word store needs no read of the old contents
            state_d     = WRITE;
            ram_wen_d   = 1'b1;
            ram_waddr_d = req_word;
            ram_wdata_d = bus.req_wdata;
          end else begin
            // Loads and sub-word stores both start with a read
            state_d     = READ;
            ram_ren_d   = 1'b1;
            ram_raddr_d = req_word;
          end
        end
      end

      READ: begin
        state_d = CAPTURE;
      end

      CAPTURE: begin
        if (we_q) begin
          state_d     = WRITE;
          ram_wen_d   = 1'b1;
          ram_waddr_d = word_q;
          ram_wdata_d = merged_word;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_ext;
        end
      end

      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured request and output registers; reset abandons any
  // in-flight transaction and silences all strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      word_q      <= '0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'd0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_raddr_q <= '0;
      ram_waddr_q <= '0;
      ram_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_raddr_q <= ram_raddr_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign ram_ren       = ram_ren_q;
  assign ram_wen       = ram_wen_q;
  assign ram_raddr     = ram_raddr_q;
  assign ram_waddr     = ram_waddr_q;
  assign ram_wdata     = ram_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: a behavioural 1-cycle-latency RAM sits
// behind the DUT; each request is traced cycle by cycle and compared with
// hand-computed strobes, latencies and response data.
module tb_data_mem_port;

  logic        clk;
  logic        rst;
  logic        ram_wen;
  logic        ram_ren;
  logic [7:0]  ram_waddr;
  logic [7:0]  ram_raddr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [256];

  int checks;
  int errors;

  data_mem_port_if bus ();

  data_mem_port #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_wen   (ram_wen),
    .ram_ren   (ram_ren),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the Ram block: registered read, write on wen
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from an idle DUT and trace six cycles after acceptance.
  // Expected cycle numbers count from the acceptance cycle; 0 = never.
  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input int e_ren, input int e_wen, input int e_rsp,
                         input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                         input logic e_err);
    int ren_at, wen_at, rsp_at, ren_n, wen_n, rsp_n, ready_hi;
    logic [7:0]  raddr_s, waddr_s;
    logic [31:0] wdata_s, rd_s, after_rd;
    logic        er_s, after_er;
    ren_at = 0; wen_at = 0; rsp_at = 0; ren_n = 0; wen_n = 0; rsp_n = 0; ready_hi = 0;
    raddr_s = 8'd0; waddr_s = 8'd0; wdata_s = 32'd0; rd_s = 32'd0; er_s = 1'b0;
    after_rd = 32'd0; after_er = 1'b0;
    chk({tag, ".ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (ram_ren) begin ren_n++; ren_at = c; raddr_s = ram_raddr; end
      if (ram_wen) begin wen_n++; wen_at = c; waddr_s = ram_waddr; wdata_s = ram_wdata; end
      if (bus.rsp_valid) begin rsp_n++; rsp_at = c; rd_s = bus.rsp_rdata; er_s = bus.rsp_err; end
      if (c <= e_rsp && bus.req_ready) ready_hi++;
      if (c == e_rsp + 1) begin after_rd = bus.rsp_rdata; after_er = bus.rsp_err; end
      step();
    end
    chk({tag, ".ren_cycle"}, 32'(ren_at), 32'(e_ren));
    chk({tag, ".wen_cycle"}, 32'(wen_at), 32'(e_wen));
    chk({tag, ".rsp_cycle"}, 32'(rsp_at), 32'(e_rsp));
    chk({tag, ".ren_count"}, 32'(ren_n), (e_ren != 0) ? 32'd1 : 32'd0);
    chk({tag, ".wen_count"}, 32'(wen_n), (e_wen != 0) ? 32'd1 : 32'd0);
    chk({tag, ".rsp_count"}, 32'(rsp_n), 32'd1);
    chk({tag, ".rdata"}, rd_s, e_rdata);
    chk({tag, ".err"}, {31'd0, er_s}, {31'd0, e_err});
    chk({tag, ".ready_busy"}, 32'(ready_hi), 32'd0);
    chk({tag, ".rdata_after"}, after_rd, 32'd0);
    chk({tag, ".err_after"}, {31'd0, after_er}, 32'd0);
    if (e_ren != 0) chk({tag, ".raddr"}, {24'd0, raddr_s}, {24'd0, addr[9:2]});
    if (e_wen != 0) begin
      chk({tag, ".waddr"}, {24'd0, waddr_s}, {24'd0, addr[9:2]});
      chk({tag, ".wdata"}, wdata_s, e_wdata);
    end
    $display("TXN %s we=%0d addr=%h size=%0d rsp_cycle=%0d rdata=%h err=%0d",
             tag, we, addr, size, rsp_at, rd_s, er_s);
  endtask

  initial begin
    int          acc [4];
    int          rspc [4];
    logic [31:0] rsd [4];
    int          idx, rn;
    int          exp_acc [4];
    int          exp_rsp [4];
    logic [31:0] exp_rd [4];

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
    bus.req_size = 2'd0; bus.req_unsigned = 1'b0; bus.req_wdata = 32'd0;

    // Reset state
    step(); step(); step();
    chk("rst.ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst.ren", {31'd0, ram_ren}, 32'd0);
    chk("rst.wen", {31'd0, ram_wen}, 32'd0);
    chk("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst.rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    step();

    // Word store / word load
    run_req("st_w_4",  1'b1, 32'h4, 2'd2, 1'b0, 32'hDEADBEEF, 0, 1, 2, 32'hDEADBEEF, 32'd0, 1'b0);
    run_req("ld_w_4",  1'b0, 32'h4, 2'd2, 1'b0, 32'd0, 1, 0, 3, 32'd0, 32'hDEADBEEF, 1'b0);

    // Byte store by read-modify-write, then sub-word loads
    run_req("st_b_6",  1'b1, 32'h6, 2'd0, 1'b0, 32'h123456A5, 1, 3, 4, 32'hDEA5BEEF, 32'd0, 1'b0);
    run_req("ld_b_6s", 1'b0, 32'h6, 2'd0, 1'b0, 32'd0, 1, 0, 3, 32'd0, 32'hFFFFFFA5, 1'b0);
    run_req("ld_b_6u", 1'b0, 32'h6, 2'd0, 1'b1, 32'd0, 1, 0, 3, 32'd0, 32'h000000A5, 1'b0);
    run_req("ld_h_4s", 1'b0, 32'h4, 2'd1, 1'b0, 32'd0, 1, 0, 3, 32'd0, 32'hFFFFBEEF, 1'b0);
    run_req("ld_h_6u", 1'b0, 32'h6, 2'd1, 1'b1, 32'd0, 1, 0, 3, 32'd0, 32'h0000DEA5, 1'b0);
    run_req("ld_w_4b", 1'b0, 32'h4, 2'd2, 1'b0, 32'd0, 1, 0, 3, 32'd0, 32'hDEA5BEEF, 1'b0);

    // Error responses
    run_req("err_ldw5",  1'b0, 32'h5,   2'd2, 1'b0, 32'd0, 0, 0, 1, 32'd0, 32'd0, 1'b1);
    run_req("err_sth3",  1'b1, 32'h3,   2'd1, 1'b0, 32'hFFFF, 0, 0, 1, 32'd0, 32'd0, 1'b1);
    run_req("err_size3", 1'b0, 32'h0,   2'd3, 1'b0, 32'd0, 0, 0, 1, 32'd0, 32'd0, 1'b1);
    run_req("err_range", 1'b0, 32'h400, 2'd2, 1'b0, 32'd0, 0, 0, 1, 32'd0, 32'd0, 1'b1);

    // Handshake: valid held high with alternating store/load
    idx = 0; rn = 0;
    for (int i = 0; i < 4; i++) begin acc[i] = -1; rspc[i] = -1; rsd[i] = 32'hX; end
    exp_acc[0] = 0; exp_acc[1] = 3; exp_acc[2] = 7;  exp_acc[3] = 10;
    exp_rsp[0] = 2; exp_rsp[1] = 6; exp_rsp[2] = 9;  exp_rsp[3] = 13;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'h11111111; exp_rd[2] = 32'd0; exp_rd[3] = 32'h22222222;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) begin
        bus.req_valid    = 1'b1;
        bus.req_we       = (idx % 2 == 0);
        bus.req_addr     = (idx < 2) ? 32'h8 : 32'hC;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = (idx < 2) ? 32'h11111111 : 32'h22222222;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.rsp_valid && rn < 4) begin rspc[rn] = c; rsd[rn] = bus.rsp_rdata; rn++; end
      if (bus.req_valid && bus.req_ready) begin
        if (idx < 4) acc[idx] = c;
        idx++;
      end
      step();
    end
    bus.req_valid = 1'b0;
    chk("hs.accepts", 32'(idx), 32'd4);
    chk("hs.responses", 32'(rn), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hs.acc%0d", i), 32'(acc[i]), 32'(exp_acc[i]));
      chk($sformatf("hs.rsp%0d", i), 32'(rspc[i]), 32'(exp_rsp[i]));
      chk($sformatf("hs.rd%0d", i), rsd[i], exp_rd[i]);
      $display("TXN hs%0d accepted=%0d rsp=%0d rdata=%h", i, acc[i], rspc[i], rsd[i]);
    end

    // Reset during CAPTURE of a half store to address 0
    run_req("st_w_0", 1'b1, 32'h0, 2'd2, 1'b0, 32'h13572468, 0, 1, 2, 32'h13572468, 32'd0, 1'b0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h0;
    bus.req_size = 2'd1; bus.req_unsigned = 1'b0; bus.req_wdata = 32'h0000CAFE;
    step();
    bus.req_valid = 1'b0;
    chk("rstmid.ren", {31'd0, ram_ren}, 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("rstmid.wen1", {31'd0, ram_wen}, 32'd0);
    chk("rstmid.rsp1", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rstmid.ready1", {31'd0, bus.req_ready}, 32'd0);
    step();
    chk("rstmid.wen2", {31'd0, ram_wen}, 32'd0);
    chk("rstmid.rsp2", {31'd0, bus.rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid.ready_after", {31'd0, bus.req_ready}, 32'd1);
    chk("rstmid.wen3", {31'd0, ram_wen}, 32'd0);
    $display("TXN rstmid half store abandoned");
    step();
    run_req("ld_w_0", 1'b0, 32'h0, 2'd2, 1'b0, 32'd0, 1, 0, 3, 32'd0, 32'h13572468, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Initiator-side controller for the single-port-pair synchronous `Ram` block (`wen`/`ren`/`waddr`/`raddr`/`wdata`/`rdata`, 1-cycle read latency) used as rv32i data memory. It sits between the core's load/store stage and `Ram`. It accepts one byte-addressed load or store at a time over a valid/ready handshake and performs byte and halfword stores by read-modify-write, since `Ram` has no byte enables. It returns sign- or zero-extended load data and error responses.

## Interface
- `ADDR_WIDTH`, default 8: `Ram` word-address width. The word count is 2^ADDR_WIDTH.
- `clk` input 1: clock. All logic is on the rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when both `req_valid` and `req_ready` are high at an edge.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` input 1: loads only; selects zero-extension.
- `req_wdata` input 32: store data. Right-aligned for sub-word stores.
- `rsp_valid` output 1: single-cycle response pulse. No backpressure.
- `rsp_rdata` output 32: load result. 0 for stores and for errors.
- `rsp_err` output 1: request rejected; no RAM access was made.
- `ram_wen`, `ram_ren` output 1: strobes to `Ram`.
- `ram_waddr`, `ram_raddr` output ADDR_WIDTH: word addresses.
- `ram_wdata` output 32: write data.
- `ram_rdata` input 32: `Ram` read data. Valid the cycle after `ram_ren`.

## Operation
- Word address = `req_addr[ADDR_WIDTH+1:2]`. Lane = `req_addr[1:0]`.
- Error conditions (any one triggers):
  - `req_size`==3;
  - half with `addr[0]`=1;
  - word with `addr[1:0]`!=0;
  - any of `req_addr[31:ADDR_WIDTH+2]` nonzero.
- All request fields are registered at acceptance. `req_ready` = (state==IDLE) && !`rst`.
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
  - Error: IDLE→RESP.
  - Word store: IDLE→WRITE→RESP.
  - Load: IDLE→READ→CAPTURE→RESP.
  - Byte/half store: IDLE→READ→CAPTURE→WRITE→RESP.
  - RESP→IDLE always.
- READ: `ram_ren`=1 and `ram_raddr`=word address, for exactly one cycle.
- CAPTURE: `ram_rdata` is sampled.
  - Load: lane extract, then sign/zero extend into the `rsp_rdata` register.
  - Sub-word store: merged word is written into the `ram_wdata` register.
- Lane rules:
  - Byte lane k occupies bits [8k+7:8k] and takes `req_wdata[7:0]`.
  - Half lane h = `addr[1]` occupies bits [16h+15:16h] and takes `req_wdata[15:0]`.
  - Other bits keep the old RAM value.
  - Sign bit is bit 7 (byte) or bit 15 (half).
- WRITE: `ram_wen`=1 for one cycle, with `ram_waddr` and `ram_wdata` set. Word stores write `req_wdata` unmodified.
- RESP: `rsp_valid`=1 and `rsp_err` = error flag.
- `ram_ren` and `ram_wen` are never high in the same cycle. Neither is asserted for errored requests.
- All RAM-side and response outputs are registered; none depend combinationally on request inputs.

## Timing
- Reset values: all outputs are 0 while `rst` is high, including `req_ready`. State = IDLE.
- Cycle N is the acceptance cycle. Latency after it:
  - Error: `rsp_valid` at N+1.
  - Word store: `ram_wen` at N+1, `rsp_valid` at N+2.
  - Load: `ram_ren` at N+1, data sampled at N+2, `rsp_valid` at N+3.
  - Sub-word store: `ram_ren` at N+1, `ram_wen` at N+3, `rsp_valid` at N+4.
- Next request can be accepted in the cycle after RESP, so back-to-back loads issue one per 4 cycles.
- `rsp_rdata` and `rsp_err` are valid only while `rsp_valid`=1. They return to 0 the next cycle.
- `req_valid` held while `req_ready`=0 is not consumed. No request queueing.
- Reset mid-operation: the transaction is abandoned.
  - No `rsp_valid` is issued.
  - Strobes are low from the cycle after the reset edge.
  - A `ram_wen` already high in the reset-sampling cycle still commits (`Ram` samples it); all later strobes are suppressed.
  - `req_ready` rises the first cycle after `rst` drops.

## Test plan
- Word store: addr 0x4, data 0xDEADBEEF → `ram_wen`=1 at N+1 only, with `ram_waddr`=1 and `ram_wdata`=0xDEADBEEF. Then `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0 at N+2.
- Word load: addr 0x4 → `ram_ren`=1 with `ram_raddr`=1 at N+1, `ram_wen` never asserted. Then `rsp_rdata`=0xDEADBEEF at N+3.
- Byte store: 0x1234_56A5 to addr 0x6 → read of word 1 at N+1, then write of 0xDEA5BEEF at N+3, `rsp_valid` at N+4. Follow-up loads:
  - signed byte at 0x6 → 0xFFFFFFA5;
  - unsigned byte at 0x6 → 0x000000A5;
  - signed half at 0x4 → 0xFFFFBEEF;
  - unsigned half at 0x6 → 0x0000DEA5.
- Errors, each giving `rsp_valid`=1 and `rsp_err`=1 at N+1, `rsp_rdata`=0, no `ram_ren`/`ram_wen`:
  - word load at 0x5;
  - half store at 0x3;
  - `req_size`=3;
  - addr 0x400 with ADDR_WIDTH=8.
- Handshake: `req_valid` held high continuously with alternating load/store → `req_ready` low from N+1 through RESP. Each request is accepted exactly once, in order, and responses match the latencies above.
- Reset in CAPTURE of a half store to 0x0 → no `ram_wen`, no `rsp_valid`, word 0 unchanged on a later read. `req_ready`=1 the cycle after `rst` deasserts.
